// File: rtl/regfile_mp_if.sv
// Register-file access bundle: read ports, writeback, scoreboard set, and busy.
// The master drives addresses and writes; the slave is the register file.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                sb_set;
    logic [AW-1:0]       sb_set_addr;
    logic                busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_set_addr,
        input  rd_data, rd_pending, busy
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_set_addr,
        output rd_data, rd_pending, busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-pending scoreboard and a clear sequencer,
// so storage needs no reset. Optional write-to-read forwarding under `RF_BYPASS_EN.

module regfile_mp_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] word,
    input  logic            pend,
    input  logic            busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] data,
    output logic            pending
);
`ifdef RF_BYPASS_EN
    always_comb begin
        data    = '0;
        pending = 1'b0;
        if (!busy && addr != '0) begin
            data    = word;
            pending = pend;
            if (wr_en && wr_addr == addr) begin
                data    = wr_data;
                pending = 1'b0;
            end
        end
    end
`else
    logic unused_byp;
    assign unused_byp = ^{wr_en, wr_addr, wr_data};

    always_comb begin
        data    = '0;
        pending = 1'b0;
        if (!busy && addr != '0) begin
            data    = word;
            pending = pend;
        end
    end
`endif
endmodule

module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    typedef enum logic {CLEAR, READY} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [NREGS-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   mem_q [NREGS];

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic              busy, wr_ok, sb_ok;

    assign busy  = (state_q == CLEAR);
    assign wr_ok = bus.wr_en  && bus.wr_addr     != '0 && !busy;
    assign sb_ok = bus.sb_set && bus.sb_set_addr != '0 && !busy;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            // Terminal count holds rather than wrapping into x0.
            if (cnt_q == AW'(NREGS-1)) state_d = READY;
            else                       cnt_d   = cnt_q + 1'b1;
        end else begin
            mem_we = wr_ok;
            // Clear first so a same-address set re-marks the destination.
            if (wr_ok) pend_d[bus.wr_addr]     = 1'b0;
            if (sb_ok) pend_d[bus.sb_set_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= AW'(1);
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem_q[mem_waddr] <= mem_wdata;
    end

    logic [NRD-1:0][XLEN-1:0] rd_data_w;
    logic [NRD-1:0]           rd_pend_w;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] a;
        assign a = bus.rd_addr[p*AW +: AW];
        regfile_mp_rdport #(.XLEN(XLEN), .AW(AW)) u_rd (
            .addr    (a),
            .word    (mem_q[a]),
            .pend    (pend_q[a]),
            .busy    (busy),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .data    (rd_data_w[p]),
            .pending (rd_pend_w[p])
        );
    end

    assign bus.rd_data    = rd_data_w;
    assign bus.rd_pending = rd_pend_w;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes model-predicted outputs,
// a negedge monitor pops and compares. A second NREGS=16/NRD=3 instance is also exercised.
module tb_regfile_mp;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) u_dut (.clk(clk), .reset(reset), .bus(bus));

    regfile_mp_if #(.XLEN(32), .NREGS(16), .NRD(3)) bus2 ();
    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        logic                busy;
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      pend;
    } exp_t;

    exp_t expq[$];
    exp_t me;
    int errors = 0, checks = 0;

    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_pend [NREGS];
    int              m_busy = 0;
    bit              m_valid = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, predict outputs from the model, advance the model at the edge.
    task automatic cyc(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                       input logic we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input logic sbs, input logic [AW-1:0] sba);
        exp_t e;
        logic [AW-1:0] ra [NRD];
        ra[0] = ra0;
        ra[1] = ra1;
        bus.rd_addr     = {ra1, ra0};
        bus.wr_en       = we;
        bus.wr_addr     = wa;
        bus.wr_data     = wd;
        bus.sb_set      = sbs;
        bus.sb_set_addr = sba;
        if (m_valid) begin
            e.busy = (m_busy > 0);
            e.data = '0;
            e.pend = '0;
            for (int p = 0; p < NRD; p++) begin
                if (!e.busy && ra[p] != 0) begin
                    if (BYP && we && wa == ra[p]) begin
                        e.data[p*XLEN +: XLEN] = wd;
                    end else begin
                        e.data[p*XLEN +: XLEN] = m_mem[ra[p]];
                        e.pend[p]              = m_pend[ra[p]];
                    end
                end
            end
            expq.push_back(e);
        end
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b1;
            m_busy  = NREGS - 1;
            for (int i = 0; i < NREGS; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (sbs && sba != 0) m_pend[sba] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        cyc(AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1)), 1'b0, '0, '0, 1'b0, '0);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            me = expq.pop_front();
            chk("busy",       {127'd0, bus.busy},        {127'd0, me.busy});
            chk("rd_data",    {64'd0, bus.rd_data},      {64'd0, me.data});
            chk("rd_pending", {126'd0, bus.rd_pending},  {126'd0, me.pend});
        end
    end

    initial begin
        int n;
        reset = 1'b1;
        bus2.rd_addr = '0; bus2.wr_en = 1'b0; bus2.wr_addr = '0;
        bus2.wr_data = '0; bus2.sb_set = 1'b0; bus2.sb_set_addr = '0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (34) idle();

        cyc(0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        cyc(5, 5, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 32'h1234, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        cyc(7, 7, 0, 0, 0, 1, 7);
        cyc(7, 7, 1, 7, 32'h42, 0, 0);
        cyc(7, 0, 0, 0, 0, 0, 0);
        cyc(7, 7, 1, 7, 32'h55, 1, 7);
        cyc(7, 7, 0, 0, 0, 1, 0);

        cyc(9, 9, 1, 9, 32'hA5A5A5A5, 0, 0);
        cyc(9, 9, 0, 0, 0, 0, 0);

        reset = 1'b1; cyc(3, 5, 0, 0, 0, 0, 0); reset = 1'b0;
        repeat (9) cyc(3, 5, 0, 0, 0, 0, 0);
        reset = 1'b1; cyc(3, 5, 0, 0, 0, 0, 0); reset = 1'b0;
        cyc(3, 3, 1, 3, 32'hCAFE, 0, 0);
        repeat (35) cyc(3, 5, 0, 0, 0, 0, 0);

        repeat (400) begin
            cyc(AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1)),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, NREGS-1)), $urandom,
                1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, NREGS-1)));
        end

        reset = 1'b1; idle(); reset = 1'b0;
        n = 0;
        while (bus2.busy && n < 100) begin
            idle();
            n++;
        end
        chk("busy_len_16", 128'(n), 128'd15);
        bus2.wr_en = 1'b1; bus2.wr_addr = 4'd15; bus2.wr_data = 32'hFFFFFFFF;
        idle();
        bus2.wr_en = 1'b0;
        bus2.rd_addr = {4'd15, 4'd0, 4'd15};
        #1;
        chk("nrd3_data", {32'd0, bus2.rd_data}, {32'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF});
        chk("nrd3_pend", {125'd0, bus2.rd_pending}, 128'd0);

        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
